// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes {pc, instr} from fetch and buffers the bundle in a FIFO.
// Optional macro DECODE_M_EXT_EN adds out_muldiv and decodes the RV32M register-register ops.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_alu_control,
  output logic            out_alu_src,
  output logic            out_alu_a_pc,
  output logic [1:0]      out_result_src,
  output logic            out_mem_write,
  output logic            out_reg_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
`ifdef DECODE_M_EXT_EN
  ,output logic           out_muldiv
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [3:0]      alu_control;
    logic            alu_src;
    logic            alu_a_pc;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            illegal;
`ifdef DECODE_M_EXT_EN
    logic            muldiv;
`endif
  } bundle_t;

  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm32;
  bundle_t     w_dec;
  bundle_t     w_head;
  logic        w_full;
  logic        w_push;
  logic        w_pop;

  bundle_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  // Instruction decode; an illegal word keeps its raw fields but has every enable cleared.
  always_comb begin
    w_dec         = '0;
    w_imm32       = 32'd0;
    w_dec.pc      = in_pc;
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.rd      = in_instr[11:7];
    w_dec.funct3  = w_funct3;
    case (w_opcode)
      7'b0110111: begin
        w_dec.alu_control = ALU_PASSB;
        w_dec.alu_src     = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_imm32           = {in_instr[31:12], 12'd0};
      end
      7'b0010111: begin
        w_dec.alu_control = ALU_ADD;
        w_dec.alu_a_pc    = 1'b1;
        w_dec.alu_src     = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_imm32           = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        w_dec.jump        = 1'b1;
        w_dec.alu_a_pc    = 1'b1;
        w_dec.alu_control = ALU_ADD;
        w_dec.result_src  = 2'b10;
        w_dec.reg_write   = 1'b1;
        w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b1100111: begin
        w_dec.jump        = 1'b1;
        w_dec.alu_control = ALU_ADD;
        w_dec.alu_src     = 1'b1;
        w_dec.result_src  = 2'b10;
        w_dec.reg_write   = 1'b1;
        w_imm32           = {{21{in_instr[31]}}, in_instr[30:20]};
      end
      7'b1100011: begin
        w_dec.branch      = 1'b1;
        w_dec.alu_control = ALU_SUB;
        w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0000011: begin
        w_dec.alu_control = ALU_ADD;
        w_dec.alu_src     = 1'b1;
        w_dec.result_src  = 2'b01;
        w_dec.reg_write   = 1'b1;
        w_imm32           = {{21{in_instr[31]}}, in_instr[30:20]};
      end
      7'b0100011: begin
        w_dec.alu_control = ALU_ADD;
        w_dec.alu_src     = 1'b1;
        w_dec.mem_write   = 1'b1;
        w_imm32           = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
      end
      7'b0010011: begin
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_imm32         = {{21{in_instr[31]}}, in_instr[30:20]};
        // Only the shift forms constrain imm[11:5]; SRAI is the sole non-zero pattern.
        if (w_funct3 == 3'b001) begin
          if (w_funct7 == F7_ZERO) begin
            w_dec.alu_control = ALU_SLL;
          end else begin
            w_dec.illegal = 1'b1;
          end
        end else if (w_funct3 == 3'b101) begin
          if (w_funct7 == F7_ZERO) begin
            w_dec.alu_control = ALU_SRL;
          end else if (w_funct7 == F7_ALT) begin
            w_dec.alu_control = ALU_SRA;
          end else begin
            w_dec.illegal = 1'b1;
          end
        end else begin
          w_dec.alu_control = alu_from_funct3(w_funct3);
        end
      end
      7'b0110011: begin
        w_dec.reg_write = 1'b1;
        if (w_funct7 == F7_ZERO) begin
          w_dec.alu_control = alu_from_funct3(w_funct3);
        end else if ((w_funct7 == F7_ALT) && (w_funct3 == 3'b000)) begin
          w_dec.alu_control = ALU_SUB;
        end else if ((w_funct7 == F7_ALT) && (w_funct3 == 3'b101)) begin
          w_dec.alu_control = ALU_SRA;
`ifdef DECODE_M_EXT_EN
        end else if (w_funct7 == 7'b0000001) begin
          w_dec.alu_control = ALU_ADD;
          w_dec.muldiv      = 1'b1;
`endif
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      7'b0001111: begin
        w_dec.illegal = 1'b0;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    if (w_dec.illegal) begin
      w_dec.imm         = '0;
      w_dec.alu_control = 4'd0;
      w_dec.alu_src     = 1'b0;
      w_dec.alu_a_pc    = 1'b0;
      w_dec.result_src  = 2'b00;
      w_dec.mem_write   = 1'b0;
      w_dec.reg_write   = 1'b0;
      w_dec.branch      = 1'b0;
      w_dec.jump        = 1'b0;
`ifdef DECODE_M_EXT_EN
      w_dec.muldiv      = 1'b0;
`endif
    end else begin
      w_dec.imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};
    end
  end

  // Handshake qualifiers; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    w_full    = (r_count == CNT_FULL);
    out_valid = (r_count != '0);
    w_pop     = out_valid & out_ready;
    in_ready  = !w_full | w_pop;
    w_push    = in_valid & in_ready;
  end

  // FIFO state: reset beats flush, and both discard the push of their cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head selection; fields read as zero while the FIFO is empty.
  always_comb begin
    if (out_valid) begin
      w_head = r_mem[r_rd_ptr];
    end else begin
      w_head = '0;
    end
  end

  assign out_pc          = w_head.pc;
  assign out_rs1         = w_head.rs1;
  assign out_rs2         = w_head.rs2;
  assign out_rd          = w_head.rd;
  assign out_imm         = w_head.imm;
  assign out_funct3      = w_head.funct3;
  assign out_alu_control = w_head.alu_control;
  assign out_alu_src     = w_head.alu_src;
  assign out_alu_a_pc    = w_head.alu_a_pc;
  assign out_result_src  = w_head.result_src;
  assign out_mem_write   = w_head.mem_write;
  assign out_reg_write   = w_head.reg_write;
  assign out_branch      = w_head.branch;
  assign out_jump        = w_head.jump;
  assign out_illegal     = w_head.illegal;
`ifdef DECODE_M_EXT_EN
  assign out_muldiv      = w_head.muldiv;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus FIFO/flush/reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_control;
  logic [1:0]  out_result_src;
  logic        out_alu_src, out_alu_a_pc, out_mem_write, out_reg_write;
  logic        out_branch, out_jump, out_illegal;
`ifdef DECODE_M_EXT_EN
  logic        out_muldiv;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  decode_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_funct3(out_funct3), .out_alu_control(out_alu_control),
    .out_alu_src(out_alu_src), .out_alu_a_pc(out_alu_a_pc),
    .out_result_src(out_result_src), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal)
`ifdef DECODE_M_EXT_EN
    ,.out_muldiv(out_muldiv)
`endif
  );

  always #5 clk = ~clk;

  // ctl = {alu_src, alu_a_pc, result_src[1:0], mem_write, reg_write, branch, jump}
  typedef struct {
    logic [31:0] instr;
    logic        chk_imm;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [7:0]  ctl;
    logic        illegal;
    logic        muldiv;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  function automatic vec_t mk(input logic [31:0] i, input logic ci, input logic [31:0] imm,
                              input logic [3:0] a, input logic [7:0] c, input logic il,
                              input logic md);
    vec_t v;
    v.instr = i; v.chk_imm = ci; v.imm = imm; v.alu = a; v.ctl = c;
    v.illegal = il; v.muldiv = md;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int next;
    int popped;
    logic [31:0] want;

    vecs.push_back(mk(32'h0050_0093, 1'b1, 32'h0000_0005, 4'd0,  8'b1000_0100, 1'b0, 1'b0)); // addi
    vecs.push_back(mk(32'hFE00_0EE3, 1'b1, 32'hFFFF_FFFC, 4'd1,  8'b0000_0010, 1'b0, 1'b0)); // beq
    vecs.push_back(mk(32'h1234_5037, 1'b1, 32'h1234_5000, 4'd10, 8'b1000_0100, 1'b0, 1'b0)); // lui
    vecs.push_back(mk(32'h0000_007F, 1'b0, 32'h0,         4'd0,  8'b0000_0000, 1'b1, 1'b0)); // bad opcode
    vecs.push_back(mk(32'h0000_1297, 1'b1, 32'h0000_1000, 4'd0,  8'b1100_0100, 1'b0, 1'b0)); // auipc
    vecs.push_back(mk(32'h0100_00EF, 1'b1, 32'h0000_0010, 4'd0,  8'b0110_0101, 1'b0, 1'b0)); // jal +16
    vecs.push_back(mk(32'hFFC0_8067, 1'b1, 32'hFFFF_FFFC, 4'd0,  8'b1010_0101, 1'b0, 1'b0)); // jalr -4
    vecs.push_back(mk(32'h0080_A103, 1'b1, 32'h0000_0008, 4'd0,  8'b1001_0100, 1'b0, 1'b0)); // lw
    vecs.push_back(mk(32'hFE20_AE23, 1'b1, 32'hFFFF_FFFC, 4'd0,  8'b1000_1000, 1'b0, 1'b0)); // sw -4
    vecs.push_back(mk(32'h4020_81B3, 1'b1, 32'h0,         4'd1,  8'b0000_0100, 1'b0, 1'b0)); // sub
    vecs.push_back(mk(32'h4020_D1B3, 1'b1, 32'h0,         4'd7,  8'b0000_0100, 1'b0, 1'b0)); // sra
    vecs.push_back(mk(32'h4030_D093, 1'b1, 32'h0000_0403, 4'd7,  8'b1000_0100, 1'b0, 1'b0)); // srai
    vecs.push_back(mk(32'h4030_9093, 1'b0, 32'h0,         4'd0,  8'b0000_0000, 1'b1, 1'b0)); // slli bad
    vecs.push_back(mk(32'h0020_F1B3, 1'b1, 32'h0,         4'd9,  8'b0000_0100, 1'b0, 1'b0)); // and
    vecs.push_back(mk(32'hFFF0_B093, 1'b1, 32'hFFFF_FFFF, 4'd4,  8'b1000_0100, 1'b0, 1'b0)); // sltiu
    vecs.push_back(mk(32'h0FF0_000F, 1'b0, 32'h0,         4'd0,  8'b0000_0000, 1'b0, 1'b0)); // fence
    vecs.push_back(mk(32'h0000_0073, 1'b0, 32'h0,         4'd0,  8'b0000_0000, 1'b1, 1'b0)); // ecall
    vecs.push_back(mk(32'h4020_9133, 1'b0, 32'h0,         4'd0,  8'b0000_0000, 1'b1, 1'b0)); // sll f7 bad
`ifdef DECODE_M_EXT_EN
    vecs.push_back(mk(32'h0220_8033, 1'b1, 32'h0,         4'd0,  8'b0000_0100, 1'b0, 1'b1)); // mul
`else
    vecs.push_back(mk(32'h0220_8033, 1'b0, 32'h0,         4'd0,  8'b0000_0000, 1'b1, 1'b0)); // mul
`endif

    // Reset state and first-transaction latency
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_imm",   out_imm,   0);
    reset = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    #2;
    chk("lat_no_comb_path", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_alu", out_alu_control, 0);
    chk("addi_src", out_alu_src, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_rw", out_reg_write, 1);
    out_ready = 1'b1;
    tick();
    chk("addi_popped", out_valid, 0);

    // Backpressure: third push stalls, then order 0x0, 0x4, 0x8
    out_ready = 1'b0; in_valid = 1'b1; in_instr = NOP;
    in_pc = 32'h0; tick();
    in_pc = 32'h4; tick();
    in_pc = 32'h8; #2;
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1; #2;
    chk("bp_pushpop_ready", in_ready, 1);
    chk("bp_pop0", out_pc, 32'h0);
    tick();
    in_valid = 1'b0; #2;
    chk("bp_pop1", out_pc, 32'h4);
    tick(); #2;
    chk("bp_pop2", out_pc, 32'h8);
    tick(); #2;
    chk("bp_empty", out_valid, 0);

    // Full FIFO streaming with 10 pushes (pointer wrap, order, count steady at 2)
    exp_q.delete(); next = 0; popped = 0;
    for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
      in_valid  = (next < 10);
      in_pc     = 32'h200 + 32'(4 * next);
      out_ready = (cyc >= 2);
      #2;
      if (cyc >= 2 && cyc <= 9) begin
        chk($sformatf("stream_valid_c%0d", cyc), out_valid, 1);
        chk($sformatf("stream_ready_c%0d", cyc), in_ready, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_pop", out_pc, 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          chk($sformatf("stream_order_%0d", popped), out_pc, want);
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_pc);
        next++;
      end
      if (cyc == 5) begin
        out_ready = 1'b0; #1;
        chk("stream_full_count2", in_ready, 0);
        out_ready = 1'b1; #1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_all_popped", popped, 10);
    chk("stream_drained", out_valid, 0);

    // Flush with two entries queued and an instruction handshaked in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h300; tick();
    in_pc = 32'h304; tick();
    in_pc = 32'h308; out_ready = 1'b1; flush = 1'b1; #2;
    chk("flush_in_ready", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_pc", out_pc, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flush_stays_empty_%0d", k), out_valid, 0);
    end
    in_valid = 1'b1; in_pc = 32'h30C; tick();
    in_valid = 1'b0;
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_pc", out_pc, 32'h30C);
    tick();

    // Reset mid-stream, with reset and flush together
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h400; tick();
    in_pc = 32'h404; tick();
    in_pc = 32'h408; reset = 1'b1; flush = 1'b1; tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("mid_rst_no_output", out_valid, 0);

    // Decode vector table
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(4 * i);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("vec%0d_ctl", i),
          {out_alu_src, out_alu_a_pc, out_result_src, out_mem_write, out_reg_write,
           out_branch, out_jump}, vecs[i].ctl);
      chk($sformatf("vec%0d_alu", i), out_alu_control, vecs[i].alu);
      chk($sformatf("vec%0d_illegal", i), out_illegal, vecs[i].illegal);
      chk($sformatf("vec%0d_funct3", i), out_funct3, vecs[i].instr[14:12]);
      if (vecs[i].chk_imm) begin
        chk($sformatf("vec%0d_imm", i), out_imm, vecs[i].imm);
      end
`ifdef DECODE_M_EXT_EN
      chk($sformatf("vec%0d_muldiv", i), out_muldiv, vecs[i].muldiv);
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
